// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared instruction encodings, FSM state type and dispatch helper for the MAC array
package mac_pkg;

  localparam logic [1:0] INST_IDLE    = 2'b00;
  localparam logic [1:0] INST_LOAD    = 2'b01;
  localparam logic [1:0] INST_EXEC    = 2'b10;
  localparam logic [1:0] INST_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

  // Execute takes priority when an instruction starts a new phase.
  function automatic state_t dispatch(input logic [1:0] inst);
    if (inst[1]) return EXEC;
    if (inst[0]) return LOAD;
    return IDLE;
  endfunction

endpackage

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - instruction sanitising, sticky illegal flag and load/execute/drain FSM with drain counter
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int row   = 8,
  parameter int col   = 8,
  parameter int cnt_w = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inst_w,
  input  logic       cascade,
  output logic [1:0] inst_s,
  output logic       busy,
  output logic       drain_done,
  output logic       inst_err
);

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic               done_d;

  assign inst_s = (inst_w == INST_ILLEGAL) ? INST_IDLE : inst_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: state_d = dispatch(inst_s);
      LOAD: begin
        if (inst_s == INST_EXEC) begin
          state_d = EXEC;
        end else if (inst_s == INST_IDLE) begin
          state_d = DRAIN;
          cnt_d   = cnt_w'(1);
          len_d   = cascade ? cnt_w'(row + col) : cnt_w'(col + 1);
        end
      end
      EXEC: begin
        if (inst_s == INST_LOAD) begin
          state_d = LOAD;
        end else if (inst_s == INST_IDLE) begin
          state_d = DRAIN;
          cnt_d   = cnt_w'(1);
          len_d   = cascade ? cnt_w'(row + col) : cnt_w'(col + 1);
        end
      end
      DRAIN: begin
        // A new instruction abandons the drain silently.
        if (inst_s != INST_IDLE) begin
          state_d = dispatch(inst_s);
          cnt_d   = '0;
        end else if (cnt_q == len_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      drain_done <= 1'b0;
      inst_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      busy       <= (state_d != IDLE);
      drain_done <= done_d;
      inst_err   <= inst_err | (inst_w == INST_ILLEGAL);
    end
  end

endmodule

// File: rtl/mac_row.sv
// rtl/mac_row.sv - one row of weight-stationary MAC tiles; activations and instructions ripple east, psums flow south
module mac_row
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w,
  input  logic [1:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid
);

  for (genvar c = 0; c < col; c++) begin : g_tile
    logic [bw-1:0]      a_in, a_q, w_q;
    logic [1:0]         i_in, i_q;
    logic [psum_bw-1:0] psum_q;
    logic               v_q;
    logic [2*bw-1:0]    prod;

    if (c == 0) begin : g_head
      assign a_in = in_w;
      assign i_in = inst_w;
    end else begin : g_body
      assign a_in = g_tile[c-1].a_q;
      assign i_in = g_tile[c-1].i_q;
    end

    assign prod = {{bw{1'b0}}, a_q} * {{bw{1'b0}}, w_q};

    // Tile acts on the registered activation/instruction pair so both stay aligned.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q    <= '0;
        i_q    <= INST_IDLE;
        w_q    <= '0;
        psum_q <= '0;
        v_q    <= 1'b0;
      end else begin
        a_q <= a_in;
        i_q <= i_in;
        v_q <= i_q[1];
        if (i_q == INST_LOAD) w_q <= a_q;
        if (i_q[1]) psum_q <= in_n[psum_bw*c +: psum_bw] + psum_bw'(prod);
      end
    end

    assign out_s[psum_bw*c +: psum_bw] = psum_q;
    assign valid[c]                    = v_q;
  end

endmodule

// File: rtl/mac_array_flex.sv
// rtl/mac_array_flex.sv - row x col MAC array with skewed/broadcast instruction pipeline, per-row bypass and control FSM
module mac_array_flex
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [row*bw-1:0]      in_w,
  input  logic [1:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  input  logic                   cascade,
  input  logic [row-1:0]         row_en,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   busy,
  output logic                   drain_done,
  output logic                   inst_err
);

  localparam int cnt_w = $clog2(row + col + 1);

  logic [1:0] inst_s;
  logic       row_rst;

  assign row_rst = ~reset;

  mac_array_ctrl #(
    .row   (row),
    .col   (col),
    .cnt_w (cnt_w)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .inst_w     (inst_w),
    .cascade    (cascade),
    .inst_s     (inst_s),
    .busy       (busy),
    .drain_done (drain_done),
    .inst_err   (inst_err)
  );

  for (genvar r = 0; r < row; r++) begin : g_row
    // en_q carries the enables of this row and every row below it, so each row's bit travels with its inst.
    logic [1:0]             inst_q, inst_prev, row_inst;
    logic [row-1:r]         en_q, en_prev;
    logic                   row_on;
    logic [psum_bw*col-1:0] p_in, p_out, row_out;
    logic [col-1:0]         v_in, v_out, row_valid;

    if (r == 0) begin : g_head
      assign inst_prev = inst_s;
      assign en_prev   = row_en;
      assign p_in      = in_n;
      assign v_in      = '0;
    end else begin : g_body
      assign inst_prev = cascade ? g_row[r-1].inst_q : inst_s;
      assign en_prev   = cascade ? g_row[r-1].en_q[row-1:r] : row_en[row-1:r];
      assign p_in      = g_row[r-1].p_out;
      assign v_in      = g_row[r-1].v_out;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        inst_q <= INST_IDLE;
        en_q   <= '1;
      end else begin
        inst_q <= inst_prev;
        en_q   <= en_prev;
      end
    end

    assign row_on   = en_q[r];
    assign row_inst = row_on ? inst_q : INST_IDLE;

    mac_row #(
      .bw      (bw),
      .psum_bw (psum_bw),
      .col     (col)
    ) u_row (
      .clk    (clk),
      .reset  (row_rst),
      .in_w   (in_w[bw*r +: bw]),
      .inst_w (row_inst),
      .in_n   (p_in),
      .out_s  (row_out),
      .valid  (row_valid)
    );

    assign p_out = row_on ? row_out   : p_in;
    assign v_out = row_on ? row_valid : v_in;
  end

  assign out_s = g_row[row-1].p_out;
  assign valid = g_row[row-1].v_out;

endmodule

// File: tb/tb_mac_array_flex.sv
// tb/tb_mac_array_flex.sv - directed self-checking bench for mac_array_flex
module tb_mac_array_flex;
  import mac_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_w;
  logic [1:0]   inst_w;
  logic [127:0] in_n;
  logic         cascade;
  logic [7:0]   row_en;
  logic [127:0] out_s;
  logic [7:0]   valid;
  logic         busy, drain_done, inst_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  mac_array_flex dut (
    .clk        (clk),
    .reset      (reset),
    .in_w       (in_w),
    .inst_w     (inst_w),
    .in_n       (in_n),
    .cascade    (cascade),
    .row_en     (row_en),
    .out_s      (out_s),
    .valid      (valid),
    .busy       (busy),
    .drain_done (drain_done),
    .inst_err   (inst_err)
  );

  always #5 clk = ~clk;

  wire [15:0] inst_all = {dut.g_row[7].inst_q, dut.g_row[6].inst_q, dut.g_row[5].inst_q,
                          dut.g_row[4].inst_q, dut.g_row[3].inst_q, dut.g_row[2].inst_q,
                          dut.g_row[1].inst_q, dut.g_row[0].inst_q};
  wire [1:0]  st  = dut.u_ctrl.state_q;
  wire [4:0]  cnt = dut.u_ctrl.cnt_q;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_w = '0; inst_w = 2'b00; in_n = '0; cascade = 1'b1; row_en = 8'hFF;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_err", inst_err, 0);
    step(2);
    reset = 1'b1;
    step(1);
    chk("rst_state", st, IDLE);
    chk("rst_out_s", out_s, 0);
    chk("rst_valid", valid, 0);

    // Cascaded one-cycle load, drain length row+col
    inst_w = 2'b01;
    step(1);
    chk("casc_row0", dut.g_row[0].inst_q, 2'b01);
    chk("casc_row1_early", dut.g_row[1].inst_q, 2'b00);
    chk("casc_state_load", st, LOAD);
    chk("casc_busy", busy, 1);
    inst_w = 2'b00;
    step(1);
    chk("casc_state_drain", st, DRAIN);
    step(6);
    chk("casc_row7", dut.g_row[7].inst_q, 2'b01);
    chk("casc_row6_after", dut.g_row[6].inst_q, 2'b00);
    step(9);
    chk("casc_done_early", drain_done, 0);
    chk("casc_busy_drain", busy, 1);
    step(1);
    chk("casc_done_pulse", drain_done, 1);
    chk("casc_busy_low", busy, 0);
    chk("casc_state_idle", st, IDLE);
    step(1);
    chk("casc_done_clear", drain_done, 0);

    // Broadcast execute, drain length col+1
    cascade = 1'b0;
    inst_w  = 2'b10;
    step(1);
    chk("bcast_all_rows", inst_all, 16'hAAAA);
    chk("bcast_state_exec", st, EXEC);
    step(3);
    inst_w = 2'b00;
    step(1);
    chk("bcast_state_drain", st, DRAIN);
    step(8);
    chk("bcast_done_early", drain_done, 0);
    chk("bcast_busy_drain", busy, 1);
    step(1);
    chk("bcast_done_pulse", drain_done, 1);
    chk("bcast_busy_low", busy, 0);
    step(1);
    chk("bcast_done_clear", drain_done, 0);

    // All rows bypassed: psum path is combinational
    row_en = 8'h00;
    step(1);
    in_n = {8{16'h1234}};
    #1;
    chk("byp_out_1234", out_s, {8{16'h1234}});
    chk("byp_valid", valid, 0);
    in_n = {8{16'hBEEF}};
    #1;
    chk("byp_out_beef", out_s, {8{16'hBEEF}});
    in_n = '0;

    // Weights 1, activations 1, all rows enabled
    cascade = 1'b1;
    row_en  = 8'hFF;
    in_w    = 32'h1111_1111;
    inst_w  = 2'b01;
    step(20);
    inst_w = 2'b10;
    cyc = 0;
    while (valid !== 8'hFF && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("mac8_valid", valid, 8'hFF);
    chk("mac8_sum", out_s, {8{16'd8}});
    inst_w = 2'b00;
    step(25);

    // Same data with only rows 0-3 enabled
    row_en = 8'h0F;
    step(10);
    inst_w = 2'b10;
    cyc = 0;
    while (valid !== 8'hFF && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("mac4_valid", valid, 8'hFF);
    chk("mac4_sum", out_s, {8{16'd4}});
    inst_w = 2'b00;
    row_en = 8'hFF;
    step(25);
    chk("pre_err_idle", st, IDLE);

    // Illegal instruction in IDLE, then drain abort at count 3
    inst_w = 2'b11;
    step(1);
    chk("err_set", inst_err, 1);
    chk("err_state_idle", st, IDLE);
    chk("err_busy", busy, 0);
    inst_w = 2'b00;
    step(3);
    chk("err_sticky", inst_err, 1);
    inst_w = 2'b01;
    step(1);
    inst_w = 2'b00;
    step(1);
    chk("abort_drain_entry", st, DRAIN);
    step(2);
    chk("abort_cnt3", cnt, 3);
    inst_w = 2'b01;
    step(1);
    chk("abort_state_load", st, LOAD);
    chk("abort_no_pulse", drain_done, 0);
    chk("abort_cnt_clear", cnt, 0);
    inst_w = 2'b00;
    step(1);
    step(15);
    chk("abort_redrain_early", drain_done, 0);
    step(1);
    chk("abort_redrain_pulse", drain_done, 1);

    // Reset asserted mid-execute
    inst_w = 2'b10;
    step(3);
    chk("rexec_state", st, EXEC);
    reset = 1'b0;
    #1;
    chk("rexec_busy", busy, 0);
    chk("rexec_err", inst_err, 0);
    chk("rexec_inst", inst_all, 16'h0000);
    chk("rexec_done", drain_done, 0);
    step(2);
    inst_w = 2'b00;
    reset  = 1'b1;
    step(3);
    chk("rexec_idle", st, IDLE);
    chk("rexec_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
